// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
//   state_e   : controller states (idle, running chunks, result held)
//   idx_width : width of a chunk index, at least one bit
package adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
//   a, b : CHUNK-bit operands
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out of the top bit
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sum = a + b + cin over WIDTH bits, CHUNK bits per clock,
// carry held in a register between chunks. Valid/ready on input and output.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready: result handshake (sum, cout held while waiting)
//   busy                 : chunks being computed
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW     = idx_width(NCHUNK);

    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_chunk_range_check
        $error("CHUNK must lie in 1..WIDTH");
    end
    if (WIDTH % CHUNK != 0) begin : g_width_multiple_check
        $error("WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_chunk;

    // Operand slice selection by chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a  (a_chunk),
        .b  (b_chunk),
        .ci (carry_q),
        .s  (s_chunk),
        .co (c_chunk)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = s_chunk;
                    end
                end
                carry_d = c_chunk;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NCHUNK - 1)) begin
                    cout_d  = c_chunk;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance: WIDTH=32, CHUNK=8
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [31:0] a, b, sum;

    // CHUNK=32 and CHUNK=1 instances share one input set
    logic        x_valid, x_cin;
    logic [31:0] x_a, x_b;
    logic        w_ready, w_ovalid, w_cout, w_busy;
    logic [31:0] w_sum;
    logic        n_ready, n_ovalid, n_cout, n_busy;
    logic [31:0] n_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) u_dut_wide (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(w_ready),
        .a(x_a), .b(x_b), .cin(x_cin), .out_valid(w_ovalid), .out_ready(1'b1),
        .sum(w_sum), .cout(w_cout), .busy(w_busy)
    );

    chunked_serial_adder #(.WIDTH(32), .CHUNK(1)) u_dut_narrow (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(n_ready),
        .a(x_a), .b(x_b), .cin(x_cin), .out_valid(n_ovalid), .out_ready(1'b1),
        .sum(n_sum), .cout(n_cout), .busy(n_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: true 33-bit sum {cout, sum}.
    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc);
        return {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set (block assumed idle), then wait for out_valid.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                         output int lat, output int bcnt);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tc);
        int lat, bcnt;
        do_op(ta, tb_v, tc, lat, bcnt);
        check({tag, "_result"}, {31'd0, cout, sum}, {31'd0, model(ta, tb_v, tc)});
        check({tag, "_latency"}, lat, 4);
        check({tag, "_busy_cycles"}, bcnt, 4);
        tick();  // handshake with out_ready=1
    endtask

    initial begin
        int w_lat, n_lat, cyc, got, sent;
        logic w_seen, n_seen, acc, hs, accepted;
        logic [31:0] w_res, n_res;
        logic w_co, n_co;
        logic [32:0] exp_q[$];
        logic [31:0] hold_sum;
        logic hold_cout;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        x_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);

        // Directed adds
        op_check("ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0);
        check("ff_plus_1_sum", sum, 32'h0000_0100);
        op_check("all_ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check("all_ones_cout", cout, 1);
        op_check("msb_pair", 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("msb_pair_sum", sum, 0);

        // Backpressure in DONE with a competing in_valid
        out_ready = 1'b0;
        begin
            int lat, bcnt;
            do_op(32'h1234_0000, 32'h0000_5678, 1'b1, lat, bcnt);
            check("bp_latency", lat, 4);
        end
        hold_sum = sum; hold_cout = cout;
        check("bp_result", {31'd0, cout, sum}, {31'd0, model(32'h1234_0000, 32'h0000_5678, 1'b1)});
        a = 32'd10; b = 32'd20; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_not_accepted", busy, 0);
            check("bp_hold", {31'd0, cout, sum}, {31'd0, hold_cout, hold_sum});
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        tick();
        check("bp_accept_after", busy, 1);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin tick(); cyc++; end
        check("bp_second_result", {31'd0, cout, sum}, 64'd30);
        tick();

        // CHUNK=32 and CHUNK=1 latency/result
        x_a = 32'h1234_5678; x_b = 32'h0FED_CBA8; x_cin = 1'b0; x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        w_seen = 0; n_seen = 0; w_lat = -1; n_lat = -1;
        w_res = '0; n_res = '0; w_co = 0; n_co = 0;
        for (int i = 1; i <= 60 && !(w_seen && n_seen); i++) begin
            tick();
            if (w_ovalid && !w_seen) begin w_seen = 1; w_lat = i; w_res = w_sum; w_co = w_cout; end
            if (n_ovalid && !n_seen) begin n_seen = 1; n_lat = i; n_res = n_sum; n_co = n_cout; end
        end
        check("wide_latency", w_lat, 1);
        check("wide_result", {31'd0, w_co, w_res}, 64'h2222_2220);
        check("narrow_latency", n_lat, 32);
        check("narrow_result", {31'd0, n_co, n_res}, 64'h2222_2220);

        // Reset on the second RUN cycle
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) hs = 1;
            tick();
        end
        check("midrst_no_result", hs, 0);
        op_check("three_plus_four", 32'd3, 32'd4, 1'b0);
        check("three_plus_four_sum", sum, 7);

        // Random stream: in_valid held high, out_ready random
        got = 0; sent = 0;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
        for (cyc = 0; cyc < 30000 && got < 1000; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            hs = out_valid && out_ready;
            if (hs) begin
                if (exp_q.size() == 0) check("rand_unexpected", 1, 0);
                else check("rand_result", {31'd0, cout, sum}, {31'd0, exp_q.pop_front()});
                got++;
            end
            accepted = 0;
            if (acc) begin
                exp_q.push_back(model(a, b, cin));
                sent++;
                accepted = 1;
            end
            tick();
            if (accepted) begin
                if (sent < 1000) begin
                    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("rand_count", got, 1000);
        check("rand_leftover", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
